// File: rtl/nibble_serial_add_seq.sv
// Purpose: drives one external 4-bit adder slice to add two W-bit operands, one nibble per clock, LSB nibble first.
// Latency: out_valid_o rises exactly NIBBLES edges after the input accept edge; one op per NIBBLES+2 cycles.
// Backpressure: in_ready_o is high only in IDLE; the result is held stable in DONE until out_ready_i.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   in_valid_i/in_ready_o              operand handshake; in_a_i, in_b_i (W bits), in_cin_i
//   add_x_o, add_y_o, add_cin_o        operands to the external 4-bit adder
//   add_k_i, add_cout_i                combinational result from that adder (same cycle)
//   out_valid_o/out_ready_i            result handshake; out_sum_o (W bits), out_cout_o
module nibble_serial_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4*NIBBLES-1:0] in_a_i,
  input  logic [4*NIBBLES-1:0] in_b_i,
  input  logic                 in_cin_i,
  output logic [3:0]           add_x_o,
  output logic [3:0]           add_y_o,
  output logic                 add_cin_o,
  input  logic [3:0]           add_k_i,
  input  logic                 add_cout_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4*NIBBLES-1:0] out_sum_o,
  output logic                 out_cout_o
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   sum_shift;

  // The newest nibble sum enters at the top, so after NIBBLES shifts the
  // first (least-significant) nibble has arrived at bits [3:0].
  if (NIBBLES == 1) begin : g_one
    assign sum_shift = add_k_i;
  end else begin : g_many
    assign sum_shift = {add_k_i, sum_q[W-1:4]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_sum_o   = '0;
    out_cout_o  = 1'b0;
    add_x_o     = 4'h0;
    add_y_o     = 4'h0;
    add_cin_o   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_sh_d  = in_a_i;
          b_sh_d  = in_b_i;
          carry_d = in_cin_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_x_o   = a_sh_q[3:0];
        add_y_o   = b_sh_q[3:0];
        add_cin_o = carry_q;
        a_sh_d    = a_sh_q >> 4;
        b_sh_d    = b_sh_q >> 4;
        sum_d     = sum_shift;
        // Carry out of this nibble feeds only the next one; after the last
        // nibble it is the final carry out.
        carry_d   = add_cout_i;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        out_sum_o   = sum_q;
        out_cout_o  = carry_q;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
module tb_nibble_serial_add_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-nibble instance
  logic        in_valid4 = 1'b0, in_ready4, in_cin4 = 1'b0;
  logic [15:0] in_a4 = '0, in_b4 = '0, out_sum4;
  logic [3:0]  add_x4, add_y4, add_k4;
  logic        add_cin4, add_cout4, out_valid4, out_ready4 = 1'b0, out_cout4;
  logic [4:0]  res4;

  // 1-nibble instance
  logic        in_valid1 = 1'b0, in_ready1, in_cin1 = 1'b0;
  logic [3:0]  in_a1 = '0, in_b1 = '0, out_sum1;
  logic [3:0]  add_x1, add_y1, add_k1;
  logic        add_cin1, add_cout1, out_valid1, out_ready1 = 1'b0, out_cout1;
  logic [4:0]  res1;

  // The external 4-bit ripple adder slices.
  assign res4 = {1'b0, add_x4} + {1'b0, add_y4} + {4'b0, add_cin4};
  assign add_k4 = res4[3:0];
  assign add_cout4 = res4[4];
  assign res1 = {1'b0, add_x1} + {1'b0, add_y1} + {4'b0, add_cin1};
  assign add_k1 = res1[3:0];
  assign add_cout1 = res1[4];

  nibble_serial_add_seq #(.NIBBLES(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .in_a_i(in_a4), .in_b_i(in_b4), .in_cin_i(in_cin4),
    .add_x_o(add_x4), .add_y_o(add_y4), .add_cin_o(add_cin4),
    .add_k_i(add_k4), .add_cout_i(add_cout4),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4),
    .out_sum_o(out_sum4), .out_cout_o(out_cout4)
  );

  nibble_serial_add_seq #(.NIBBLES(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .in_a_i(in_a1), .in_b_i(in_b1), .in_cin_i(in_cin1),
    .add_x_o(add_x1), .add_y_o(add_y1), .add_cin_o(add_cin1),
    .add_k_i(add_k1), .add_cout_i(add_cout1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1),
    .out_sum_o(out_sum1), .out_cout_o(out_cout1)
  );

  logic [3:0] xs [4];
  logic [3:0] ys [4];
  logic       cs [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set on the 4-nibble instance and step through RUN,
  // recording what is sent to the adder. Returns with the DUT in DONE.
  // With junk set, a different operand set is offered throughout RUN.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic junk);
    in_a4 = a; in_b4 = b; in_cin4 = cin; in_valid4 = 1'b1;
    tick();
    in_valid4 = junk;
    in_a4 = ~a; in_b4 = ~b; in_cin4 = ~cin;
    for (int i = 0; i < 4; i++) begin
      xs[i] = add_x4; ys[i] = add_y4; cs[i] = add_cin4;
      chk("run out_valid low", {31'b0, out_valid4}, 32'd0);
      tick();
    end
    in_valid4 = 1'b0;
    chk("done out_valid", {31'b0, out_valid4}, 32'd1);
    chk("done in_ready", {31'b0, in_ready4}, 32'd0);
  endtask

  task automatic release4();
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("release out_valid", {31'b0, out_valid4}, 32'd0);
    chk("release in_ready", {31'b0, in_ready4}, 32'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst in_ready4", {31'b0, in_ready4}, 32'd1);
    chk("rst out_valid4", {31'b0, out_valid4}, 32'd0);
    chk("rst out_sum4", {16'b0, out_sum4}, 32'd0);
    chk("rst out_cout4", {31'b0, out_cout4}, 32'd0);
    chk("rst add_x4", {28'b0, add_x4}, 32'd0);
    chk("rst in_ready1", {31'b0, in_ready1}, 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // T1: full carry ripple through every nibble
    op4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("T1 sum", {16'b0, out_sum4}, 32'h0000);
    chk("T1 cout", {31'b0, out_cout4}, 32'd1);
    chk("T1 cin seq", {28'b0, cs[0], cs[1], cs[2], cs[3]}, 32'b0111);
    release4();

    // T2: nibble ordering, plus in_valid with other data during RUN/DONE
    op4(16'h1234, 16'h4321, 1'b0, 1'b1);
    chk("T2 sum", {16'b0, out_sum4}, 32'h5555);
    chk("T2 cout", {31'b0, out_cout4}, 32'd0);
    chk("T2 x seq", {16'b0, xs[0], xs[1], xs[2], xs[3]}, 32'h4321);
    chk("T2 y seq", {16'b0, ys[0], ys[1], ys[2], ys[3]}, 32'h1234);
    release4();

    // T3: carry-in propagation into nibble 1
    op4(16'h000F, 16'h0000, 1'b1, 1'b0);
    chk("T3 sum", {16'b0, out_sum4}, 32'h0010);
    chk("T3 cout", {31'b0, out_cout4}, 32'd0);
    chk("T3 cin seq", {28'b0, cs[0], cs[1], cs[2], cs[3]}, 32'b1100);

    // T4: result held under backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("T4 hold valid", {31'b0, out_valid4}, 32'd1);
      chk("T4 hold sum", {16'b0, out_sum4}, 32'h0010);
      chk("T4 hold cout", {31'b0, out_cout4}, 32'd0);
      chk("T4 hold in_ready", {31'b0, in_ready4}, 32'd0);
    end
    release4();

    // T5: reset mid-RUN
    in_a4 = 16'h1234; in_b4 = 16'h4321; in_cin4 = 1'b1; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick(); tick();
    chk("T5 running add_x", {28'b0, add_x4}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("T5 rst in_ready", {31'b0, in_ready4}, 32'd1);
    chk("T5 rst out_valid", {31'b0, out_valid4}, 32'd0);
    chk("T5 rst out_sum", {16'b0, out_sum4}, 32'd0);
    chk("T5 rst add_x", {28'b0, add_x4}, 32'd0);
    chk("T5 rst add_cin", {31'b0, add_cin4}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    op4(16'h0005, 16'h0003, 1'b0, 1'b0);
    chk("T5 sum", {16'b0, out_sum4}, 32'h0008);
    chk("T5 cout", {31'b0, out_cout4}, 32'd0);
    release4();

    // T6: single-nibble instance, back-to-back
    in_a1 = 4'b1111; in_b1 = 4'b0110; in_cin1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk("T6 run x", {28'b0, add_x1}, 32'hF);
    chk("T6 run y", {28'b0, add_y1}, 32'h6);
    chk("T6 run valid", {31'b0, out_valid1}, 32'd0);
    tick();
    chk("T6 valid", {31'b0, out_valid1}, 32'd1);
    chk("T6 sum", {28'b0, out_sum1}, 32'h5);
    chk("T6 cout", {31'b0, out_cout1}, 32'd1);
    out_ready1 = 1'b1;
    in_a1 = 4'b1001; in_b1 = 4'b1011; in_valid1 = 1'b1;
    tick();
    chk("T6 idle valid", {31'b0, out_valid1}, 32'd0);
    chk("T6 idle in_ready", {31'b0, in_ready1}, 32'd1);
    tick();
    in_valid1 = 1'b0;
    chk("T6b run in_ready", {31'b0, in_ready1}, 32'd0);
    chk("T6b run x", {28'b0, add_x1}, 32'h9);
    tick();
    chk("T6b valid", {31'b0, out_valid1}, 32'd1);
    chk("T6b sum", {28'b0, out_sum1}, 32'h4);
    chk("T6b cout", {31'b0, out_cout1}, 32'd1);
    tick();
    out_ready1 = 1'b0;
    chk("T6b released", {31'b0, out_valid1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
